// File: rtl/if_stage.sv
// Instruction fetch: PC register, prioritised next-PC select, IF/ID pipeline register, stall counter.
// Latency: fetched word reaches IF/ID one cycle after its PC; a redirect target reaches PC one cycle later.
// Backpressure: PCWr=0 holds the PC, IF_ID_Wr=0 holds IF/ID; redirects override both and flush IF/ID.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0080,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWr,
    input  logic        IF_ID_Wr,
    input  logic        Jump_ID,
    input  logic [31:0] JumpTarget_ID,
    input  logic        BranchTaken_EX,
    input  logic [31:0] BranchTarget_EX,
    input  logic        Exception,
    input  logic [31:0] Instr_in,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic [31:0] StallCount
);

    logic [31:0] pcPlus4;
    logic        redirect;

    // Sequential fetch address; wraps modulo 2^32.
    assign pcPlus4  = PC + 32'd4;
    // Any redirect squashes the wrong-path fetch, making a concurrent stall irrelevant.
    assign redirect = Exception | BranchTaken_EX | Jump_ID;

    // PC update with exception > branch > jump > stall > sequential priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            PC <= RESET_PC;
        end else if (Exception) begin
            PC <= EXC_VECTOR;
        end else if (BranchTaken_EX) begin
            PC <= BranchTarget_EX;
        end else if (Jump_ID) begin
            PC <= JumpTarget_ID;
        end else if (PCWr) begin
            PC <= pcPlus4;
        end
    end

    // IF/ID register: flush on any redirect (flush beats hold), else hold or load the fetch.
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            IF_ID_Instr   <= NOP_INSTR;
            IF_ID_PCPlus4 <= 32'd0;
            IF_ID_Valid   <= 1'b0;
        end else if (IF_ID_Wr) begin
            IF_ID_Instr   <= Instr_in;
            IF_ID_PCPlus4 <= pcPlus4;
            IF_ID_Valid   <= 1'b1;
        end
    end

    // Saturating count of genuinely stalled fetch cycles (stall not overridden by a redirect).
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount <= 32'd0;
        end else if (!PCWr && !redirect && (StallCount != 32'hFFFF_FFFF)) begin
            StallCount <= StallCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWr;
    logic        IF_ID_Wr;
    logic        Jump_ID;
    logic [31:0] JumpTarget_ID;
    logic        BranchTaken_EX;
    logic [31:0] BranchTarget_EX;
    logic        Exception;
    logic [31:0] Instr_in;
    logic [31:0] PC;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic [31:0] StallCount;

    int total = 0;
    int bad   = 0;

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .PCWr            (PCWr),
        .IF_ID_Wr        (IF_ID_Wr),
        .Jump_ID         (Jump_ID),
        .JumpTarget_ID   (JumpTarget_ID),
        .BranchTaken_EX  (BranchTaken_EX),
        .BranchTarget_EX (BranchTarget_EX),
        .Exception       (Exception),
        .Instr_in        (Instr_in),
        .PC              (PC),
        .IF_ID_Instr     (IF_ID_Instr),
        .IF_ID_PCPlus4   (IF_ID_PCPlus4),
        .IF_ID_Valid     (IF_ID_Valid),
        .StallCount      (StallCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        pcWr;
        logic        ifIdWr;
        logic        jmp;
        logic [31:0] jTgt;
        logic        br;
        logic [31:0] bTgt;
        logic        exc;
        logic [31:0] instr;
        logic [31:0] expPc;
        logic [31:0] expInstr;
        logic [31:0] expPc4;
        logic        expVld;
        logic [31:0] expStall;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic rst, logic pcWr, logic ifIdWr, logic jmp, logic [31:0] jTgt,
                                logic br, logic [31:0] bTgt, logic exc, logic [31:0] instr,
                                logic [31:0] expPc, logic [31:0] expInstr, logic [31:0] expPc4,
                                logic expVld, logic [31:0] expStall);
        vec_t v;
        v.rst = rst; v.pcWr = pcWr; v.ifIdWr = ifIdWr; v.jmp = jmp; v.jTgt = jTgt;
        v.br = br; v.bTgt = bTgt; v.exc = exc; v.instr = instr;
        v.expPc = expPc; v.expInstr = expInstr; v.expPc4 = expPc4;
        v.expVld = expVld; v.expStall = expStall;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; PCWr = v.pcWr; IF_ID_Wr = v.ifIdWr;
        Jump_ID = v.jmp; JumpTarget_ID = v.jTgt;
        BranchTaken_EX = v.br; BranchTarget_EX = v.bTgt;
        Exception = v.exc; Instr_in = v.instr;
    endtask

    task automatic stepCheck(input string tag, input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        check({tag, ".pc"},    PC,            v.expPc);
        check({tag, ".instr"}, IF_ID_Instr,   v.expInstr);
        check({tag, ".pc4"},   IF_ID_PCPlus4, v.expPc4);
        check({tag, ".vld"},   {31'd0, IF_ID_Valid}, {31'd0, v.expVld});
        check({tag, ".stall"}, StallCount,    v.expStall);
    endtask

    initial begin
        //            rst pcW ifW jmp jTgt          br  bTgt        exc instr          | PC            Instr          PC4           V  Stall
        vecs[0]  = mk(1, 1, 1, 0, 32'h0,        0, 32'h0,     0, 32'h2008_0005, 32'h0,        32'h0,         32'h0,        0, 0);
        vecs[1]  = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,     0, 32'h2008_0005, 32'h4,        32'h2008_0005, 32'h4,        1, 0);
        vecs[2]  = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,     0, 32'h2008_0005, 32'h8,        32'h2008_0005, 32'h8,        1, 0);
        vecs[3]  = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,     0, 32'h2008_0005, 32'hC,        32'h2008_0005, 32'hC,        1, 0);
        vecs[4]  = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,     0, 32'hAAAA_0001, 32'h10,       32'hAAAA_0001, 32'h10,       1, 0);
        // Load-use stall for two cycles at PC=0x10
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,     0, 32'hBBBB_0002, 32'h10,       32'hAAAA_0001, 32'h10,       1, 1);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,     0, 32'hBBBB_0002, 32'h10,       32'hAAAA_0001, 32'h10,       1, 2);
        vecs[7]  = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,     0, 32'hCCCC_0003, 32'h14,       32'hCCCC_0003, 32'h14,       1, 2);
        // Branch during a stall: redirect wins, count unchanged
        vecs[8]  = mk(0, 0, 0, 0, 32'h0,        1, 32'h40,    0, 32'hDDDD_0004, 32'h40,       32'h0,         32'h0,        0, 2);
        vecs[9]  = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,     0, 32'hDDDD_0005, 32'h44,       32'hDDDD_0005, 32'h44,       1, 2);
        // Exception + branch + jump together
        vecs[10] = mk(0, 1, 1, 1, 32'h1234_0000, 1, 32'h5678_0000, 1, 32'hEEEE_0006, 32'h8000_0080, 32'h0,     32'h0,        0, 2);
        // Jump only, then a normal fetch at the target
        vecs[11] = mk(0, 1, 1, 1, 32'h0040_0000, 0, 32'h0,    0, 32'hEEEE_0007, 32'h0040_0000, 32'h0,        32'h0,        0, 2);
        vecs[12] = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,     0, 32'hF0F0_0008, 32'h0040_0004, 32'hF0F0_0008, 32'h0040_0004, 1, 2);
        // PCWr=0 with IF_ID_Wr=1: PC holds, same fetch re-latched
        vecs[13] = mk(0, 0, 1, 0, 32'h0,        0, 32'h0,     0, 32'h1111_0009, 32'h0040_0004, 32'h1111_0009, 32'h0040_0008, 1, 3);
        // IF_ID_Wr=0 alone: IF/ID holds while PC advances
        vecs[14] = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,     0, 32'h2222_000A, 32'h0040_0008, 32'h1111_0009, 32'h0040_0008, 1, 3);
        // Jump during a full stall: flush beats hold, no stall counted
        vecs[15] = mk(0, 0, 0, 1, 32'h100,      0, 32'h0,     0, 32'h3333_000B, 32'h100,      32'h0,         32'h0,        0, 3);
        // Reset overrides a simultaneous exception
        vecs[16] = mk(1, 0, 1, 0, 32'h0,        0, 32'h0,     1, 32'h4444_000C, 32'h0,        32'h0,         32'h0,        0, 0);

        for (int i = 0; i < 17; i++) begin
            stepCheck($sformatf("row%0d", i), vecs[i]);
        end

        // PC wrap: jump to the top word, then fetch sequentially past it
        stepCheck("wrapJmp", mk(0, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h5555_000D,
                                32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0));
        stepCheck("wrapRun", mk(0, 1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h6666_000E,
                                32'h0, 32'h6666_000E, 32'h0, 1, 0));
        stepCheck("wrapNext", mk(0, 1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h7777_000F,
                                32'h4, 32'h7777_000F, 32'h4, 1, 0));

        // Reset arriving mid-stall clears PC, IF/ID and the counter
        stepCheck("midStall1", mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h8888_0010,
                                32'h4, 32'h7777_000F, 32'h4, 1, 1));
        stepCheck("midStall2", mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h8888_0010,
                                32'h4, 32'h7777_000F, 32'h4, 1, 2));
        stepCheck("midReset", mk(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h8888_0010,
                                32'h0, 32'h0, 32'h0, 0, 0));
        stepCheck("postReset", mk(0, 1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h9999_0011,
                                32'h4, 32'h9999_0011, 32'h4, 1, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
